// File: rtl/full_subtractor_cell.sv
// One bit of a ripple-borrow subtractor: d = a - b - bin, with the borrow
// passed on to the next more significant stage.
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  // Borrow when b exceeds a, or when a == b and a borrow is already pending.
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/full_subtractor.sv
// WIDTH-bit ripple-borrow subtractor: bit1 - bit2 - borrow_in.
// Provides a zero-latency result plus a copy registered on clk.
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bit1,
  input  logic [WIDTH-1:0] bit2,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic [WIDTH-1:0] diff_q,
  output logic             borrow_out_q
);

  logic [WIDTH:0]   w_borrow;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] r_diff_q;
  logic             r_borrow_out_q;

  assign w_borrow[0] = borrow_in;

  // Borrow ripples from the LSB cell up to the MSB cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_subtractor_cell u_cell (
      .a    (bit1[i]),
      .b    (bit2[i]),
      .bin  (w_borrow[i]),
      .d    (w_diff[i]),
      .bout (w_borrow[i+1])
    );
  end

  assign diff       = w_diff;
  assign borrow_out = w_borrow[WIDTH];

  // Reset clears only the registered copy; the combinational path is untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff_q       <= '0;
      r_borrow_out_q <= 1'b0;
    end else begin
      r_diff_q       <= w_diff;
      r_borrow_out_q <= w_borrow[WIDTH];
    end
  end

  assign diff_q       = r_diff_q;
  assign borrow_out_q = r_borrow_out_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Bench for full_subtractor: a 1-bit and a 4-bit instance share clock and
// reset; registered results are checked through expected-value queues.
module tb_full_subtractor;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       a1, b1, bi1;
  logic       d1, bo1, dq1, boq1;
  logic [3:0] a4, b4;
  logic       bi4;
  logic [3:0] d4, dq4;
  logic       bo4, boq4;

  full_subtractor #(.WIDTH(1)) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .bit1         (a1),
    .bit2         (b1),
    .borrow_in    (bi1),
    .diff         (d1),
    .borrow_out   (bo1),
    .diff_q       (dq1),
    .borrow_out_q (boq1)
  );

  full_subtractor #(.WIDTH(4)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .bit1         (a4),
    .bit2         (b4),
    .borrow_in    (bi4),
    .diff         (d4),
    .borrow_out   (bo4),
    .diff_q       (dq4),
    .borrow_out_q (boq4)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] exp1_q[$];  // {borrow_out, diff} for the 1-bit instance
  logic [4:0] exp4_q[$];  // {borrow_out, diff} for the 4-bit instance

  function automatic logic [1:0] model1(logic a, logic b, logic bi);
    logic [1:0] r;
    r = {1'b0, a} - {1'b0, b} - {1'b0, bi};
    return r;
  endfunction

  function automatic logic [4:0] model4(logic [3:0] a, logic [3:0] b, logic bi);
    logic [4:0] r;
    r = {1'b0, a} - {1'b0, b} - {4'b0, bi};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive1(input logic a, input logic b, input logic bi);
    a1 = a; b1 = b; bi1 = bi;
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    a4 = a; b4 = b; bi4 = bi;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    drive1(1'b0, 1'b0, 1'b1);
    drive4(4'h0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({boq1, dq1} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_q1: got %b expected 00", {boq1, dq1});
    end
    n_tests++;
    if ({boq4, dq4} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_q4: got %b expected 00000", {boq4, dq4});
    end
    n_tests++;
    if ({bo1, d1} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_comb1: got %b expected 11", {bo1, d1});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_comb_sweep;
    logic [1:0] tbl [8];
    logic [2:0] v;
    // {diff, borrow_out} for inputs {bit1, bit2, borrow_in} = 0..7
    tbl = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive1(v[2], v[1], v[0]);
      #50;
      n_tests++;
      if ({d1, bo1} !== tbl[i]) begin
        n_fail++;
        $display("FAIL sweep_%0d: got diff,bout=%b expected %b", i, {d1, bo1}, tbl[i]);
      end
      #50;
    end
  endtask

  task automatic test_registered;
    logic [1:0] e;
    logic [1:0] ins [2];
    ins = '{2'b11, 2'b01};  // expected {bout_q, diff_q} for 001 then 100
    @(negedge clk);
    drive1(1'b0, 1'b0, 1'b1);
    exp1_q.push_back(ins[0]);
    @(posedge clk); #1;
    e = exp1_q.pop_front();
    n_tests++;
    if ({boq1, dq1} !== e) begin
      n_fail++;
      $display("FAIL reg_001: got %b expected %b", {boq1, dq1}, e);
    end
    @(negedge clk);
    drive1(1'b1, 1'b0, 1'b0);
    exp1_q.push_back(ins[1]);
    @(posedge clk); #1;
    e = exp1_q.pop_front();
    n_tests++;
    if ({boq1, dq1} !== e) begin
      n_fail++;
      $display("FAIL reg_100: got %b expected %b", {boq1, dq1}, e);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({boq1, dq1} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_rst_q: got %b expected 00", {boq1, dq1});
    end
    n_tests++;
    if ({bo1, d1} !== 2'b01) begin
      n_fail++;
      $display("FAIL async_rst_comb: got %b expected 01", {bo1, d1});
    end
  endtask

  task automatic test_reset_release;
    logic [1:0] e1;
    logic [4:0] e4;
    drive4(4'hA, 4'h3, 1'b0);
    @(posedge clk); #1;
    n_tests++;
    if ({boq1, dq1, boq4, dq4} !== 7'b0) begin
      n_fail++;
      $display("FAIL hold_in_rst: got %b expected 0", {boq1, dq1, boq4, dq4});
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    exp1_q.push_back(model1(a1, b1, bi1));
    exp4_q.push_back(model4(a4, b4, bi4));
    #1;
    n_tests++;
    if ({boq1, dq1, boq4, dq4} !== 7'b0) begin
      n_fail++;
      $display("FAIL release_mid: got %b expected 0", {boq1, dq1, boq4, dq4});
    end
    @(posedge clk); #1;
    e1 = exp1_q.pop_front();
    e4 = exp4_q.pop_front();
    n_tests++;
    if ({boq1, dq1} !== e1) begin
      n_fail++;
      $display("FAIL release_q1: got %b expected %b", {boq1, dq1}, e1);
    end
    n_tests++;
    if ({boq4, dq4} !== e4) begin
      n_fail++;
      $display("FAIL release_q4: got %h expected %h", {boq4, dq4}, e4);
    end
  endtask

  // Drive one 4-bit vector, check the combinational result against a fixed
  // expectation, then check the registered copy one edge later.
  task automatic check4(input string name, input logic [3:0] a, input logic [3:0] b,
                        input logic bi, input logic [4:0] req);
    logic [4:0] e;
    @(negedge clk);
    drive4(a, b, bi);
    exp4_q.push_back(req);
    #1;
    n_tests++;
    if ({bo4, d4} !== req) begin
      n_fail++;
      $display("FAIL %s_comb: got bout=%b diff=%h expected bout=%b diff=%h",
               name, bo4, d4, req[4], req[3:0]);
    end
    @(posedge clk); #1;
    e = exp4_q.pop_front();
    n_tests++;
    if ({boq4, dq4} !== e) begin
      n_fail++;
      $display("FAIL %s_reg: got bout_q=%b diff_q=%h expected bout_q=%b diff_q=%h",
               name, boq4, dq4, e[4], e[3:0]);
    end
  endtask

  task automatic test_wrap4;
    check4("wrap_0m1", 4'h0, 4'h1, 1'b0, {1'b1, 4'hF});
    check4("sub_9m3m1", 4'h9, 4'h3, 1'b1, {1'b0, 4'h5});
  endtask

  task automatic test_chain4;
    check4("chain_0mFm1", 4'h0, 4'hF, 1'b1, {1'b1, 4'h0});
    check4("zero_eq", 4'h7, 4'h7, 1'b0, {1'b0, 4'h0});
    check4("max_m0", 4'hF, 4'h0, 1'b0, {1'b0, 4'hF});
  endtask

  task automatic test_back_to_back;
    logic [3:0] a, b;
    logic       bi, x, y, z;
    logic [4:0] e4;
    logic [1:0] e1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      bi = 1'($urandom_range(0, 1));
      x  = 1'($urandom_range(0, 1));
      y  = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      drive4(a, b, bi);
      drive1(x, y, z);
      exp4_q.push_back(model4(a, b, bi));
      exp1_q.push_back(model1(x, y, z));
      @(posedge clk); #1;
      e4 = exp4_q.pop_front();
      e1 = exp1_q.pop_front();
      n_tests++;
      if ({boq4, dq4} !== e4) begin
        n_fail++;
        $display("FAIL b2b4_%0d: %h-%h-%b got %h expected %h", i, a, b, bi, {boq4, dq4}, e4);
      end
      n_tests++;
      if ({bo4, d4} !== e4) begin
        n_fail++;
        $display("FAIL b2b4_comb_%0d: got %h expected %h", i, {bo4, d4}, e4);
      end
      n_tests++;
      if ({boq1, dq1} !== e1) begin
        n_fail++;
        $display("FAIL b2b1_%0d: %b-%b-%b got %b expected %b", i, x, y, z, {boq1, dq1}, e1);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_comb_sweep();
    test_registered();
    test_async_reset();
    test_reset_release();
    test_wrap4();
    test_chain4();
    test_back_to_back();
    if (exp1_q.size() != 0 || exp4_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL queue_drain: %0d/%0d entries left, expected 0",
               exp1_q.size(), exp4_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
Parameterizable ripple-borrow subtractor computing bit1 − bit2 − borrow_in. It is used by the counter blocks of the parking-system datapath. Results are available combinationally (zero latency) and as a registered copy one clock later. The default WIDTH=1 gives the classic 1-bit full subtractor.

Parameters:
WIDTH, 1, operand width in bits (≥1)

Ports:
clk  input  1  clock; registered outputs update on rising edge
rst  input  1  asynchronous, active-high reset; clears registered outputs only
bit1  input  WIDTH  minuend
bit2  input  WIDTH  subtrahend
borrow_in  input  1  borrow into LSB stage
diff  output  WIDTH  combinational difference
borrow_out  output  1  combinational borrow out of MSB stage
diff_q  output  WIDTH  registered diff
borrow_out_q  output  1  registered borrow_out

Interface rule: one clock (clk). Reset (rst) is asynchronous and active-high.

Behaviour:
- Per stage i, with b0 = borrow_in:
  - diff[i] = bit1[i] ^ bit2[i] ^ b_i
  - b_(i+1) = (~bit1[i] & bit2[i]) | (~(bit1[i] ^ bit2[i]) & b_i)
  - borrow_out = b_WIDTH
- Arithmetic identity: {borrow_out, diff} ≡ bit1 − bit2 − borrow_in modulo 2^(WIDTH+1). borrow_out=1 exactly when bit1 < bit2 + borrow_in (unsigned).
- diff and borrow_out are purely combinational:
  - No dependence on clk or rst.
  - Valid within the same delta/time step as any input change.
  - Defined during reset.
- diff_q and borrow_out_q capture diff and borrow_out on each rising clk edge (latency 1 cycle).
- rst asserted (any time, no clock needed): diff_q=0, borrow_out_q=0 immediately.
- Registered outputs hold 0 while rst is high. The first capture happens on the first rising edge after rst deasserts.
- Wrap-around:
  - 0 − 1 − 0 gives diff = all ones, borrow_out=1.
  - 0 − all ones − 1 gives diff = 0, borrow_out=1.
- X/Z on inputs propagate. No special handling.

Decomposition:
- No shared package needed; there are no typedefs or constants beyond WIDTH.
- One natural sub-module: full_subtractor_cell (1-bit stage: a, b, bin → d, bout).
- The top generates WIDTH cells chained LSB→MSB, plus the output register.

Test Plan:
- WIDTH=1, exhaustive combinational sweep (bit1, bit2, borrow_in) = 000..111, 100 time units each. Required (diff, borrow_out): 000→(0,0), 001→(1,1), 010→(1,1), 011→(0,1), 100→(1,0), 101→(0,0), 110→(0,0), 111→(1,1).
- Registered path: WIDTH=1, apply 001, clock once → diff_q=1, borrow_out_q=1. Apply 100, clock → diff_q=1, borrow_out_q=0.
- Async reset: with diff_q=1, raise rst between clock edges → diff_q=0 and borrow_out_q=0 immediately. Combinational diff is unaffected.
- WIDTH=4 wrap: bit1=0, bit2=1, borrow_in=0 → diff=4'hF, borrow_out=1. bit1=4'h9, bit2=4'h3, borrow_in=1 → diff=4'h5, borrow_out=0.
- WIDTH=4 full borrow chain: bit1=0, bit2=4'hF, borrow_in=1 → diff=4'h0, borrow_out=1. Registered copy matches one edge later.
- Reset release: deassert rst mid-cycle → outputs stay 0 until the next rising edge, then equal the current combinational values.
